// File: rtl/elixirchip_es1_spu_ctl_loop_if.sv
// Command and issue bundle of the SPU loop sequencer.
// s_abort exists only with ELIXIRCHIP_SPU_CTL_LOOP_ABORT_EN.
interface elixirchip_es1_spu_ctl_loop_if #(
  parameter int COUNT_BITS = 16
);
  logic                  s_start;
  logic [COUNT_BITS-1:0] s_count;
`ifdef ELIXIRCHIP_SPU_CTL_LOOP_ABORT_EN
  logic                  s_abort;
`endif
  logic                  s_ready;
  logic                  m_valid;
  logic [COUNT_BITS-1:0] m_index;
  logic                  m_first;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  modport master (
`ifdef ELIXIRCHIP_SPU_CTL_LOOP_ABORT_EN
    output s_abort,
`endif
    output s_start, s_count,
    input  s_ready, m_valid, m_index,
    input  m_first, m_last, busy, done
  );

  modport slave (
`ifdef ELIXIRCHIP_SPU_CTL_LOOP_ABORT_EN
    input  s_abort,
`endif
    input  s_start, s_count,
    output s_ready, m_valid, m_index,
    output m_first, m_last, busy, done
  );
endinterface

// File: rtl/elixirchip_es1_spu_ctl_loop.sv
// SPU loop sequencer: issues count elements, drains LATENCY, pulses done.
// Optional abort input: ELIXIRCHIP_SPU_CTL_LOOP_ABORT_EN.
module elixirchip_es1_spu_ctl_loop #(
  parameter int    LATENCY    = 3,
  parameter int    COUNT_BITS = 16,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic reset,
  input  logic clk,
  input  logic cke,
  elixirchip_es1_spu_ctl_loop_if.slave bus
);

  localparam int DW = $clog2(LATENCY + 2) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [COUNT_BITS-1:0] idx_q, idx_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [COUNT_BITS-1:0] cm1_q, cm1_d;
  logic [DW-1:0]         drain_q, drain_d;

  logic                  abort;
  logic [COUNT_BITS-1:0] idx_nx;

`ifdef ELIXIRCHIP_SPU_CTL_LOOP_ABORT_EN
  assign abort = bus.s_abort;
`else
  assign abort = 1'b0;
`endif

  assign idx_nx = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    first_d = first_q;
    last_d  = last_q;
    cm1_d   = cm1_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_start) begin
          if (bus.s_count != '0) begin
            state_d = ISSUE;
            cm1_d   = bus.s_count - 1'b1;
            valid_d = 1'b1;
            idx_d   = '0;
            first_d = 1'b1;
            last_d  = (bus.s_count == COUNT_BITS'(1));
          end else begin
            // empty loop still waits one slot plus the pipe
            state_d = DRAIN;
            drain_d = DW'(LATENCY + 1);
          end
        end
      end
      ISSUE: begin
        if (last_q || abort) begin
          valid_d = 1'b0;
          idx_d   = '0;
          first_d = 1'b0;
          last_d  = 1'b0;
          if (LATENCY == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = DW'(LATENCY);
          end
        end else begin
          idx_d   = idx_nx;
          first_d = 1'b0;
          last_d  = (idx_nx == cm1_q);
        end
      end
      DRAIN: begin
        if (drain_q <= DW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          drain_d = '0;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cm1_q   <= '0;
      drain_q <= '0;
    end else if (cke) begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      last_q  <= last_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cm1_q   <= cm1_d;
      drain_q <= drain_d;
    end
  end

  assign bus.s_ready = ready_q;
  assign bus.m_valid = valid_q;
  assign bus.m_index = idx_q;
  assign bus.m_first = first_q;
  assign bus.m_last  = last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

  if (SIMULATION == "true") begin : g_chk
    always @(posedge clk) begin
      if (!reset && valid_q && done_q) begin
        if (DEBUG == "true")
          $display("%m (%s): error: m_valid with done, state=%0d drain=%0d",
                   DEVICE, state_q, drain_q);
        else
          $display("%m (%s): error: m_valid with done", DEVICE);
      end
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_ctl_loop.sv
// Scoreboard bench for the SPU loop sequencer.
// Model: per accepted command, issue slots and done slot from timing rules.
module tb_elixirchip_es1_spu_ctl_loop;

  localparam int LAT = 3;
  localparam int CB  = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cke   = 1'b1;

  elixirchip_es1_spu_ctl_loop_if #(.COUNT_BITS(CB)) bus ();

  elixirchip_es1_spu_ctl_loop #(
    .LATENCY   (LAT),
    .COUNT_BITS(CB),
    .SIMULATION("true")
  ) dut (
    .reset(reset),
    .clk  (clk),
    .cke  (cke),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kc;
    int idx;
    bit first;
    bit last;
  } iss_t;

  iss_t iq[$];
  int   dq[$];
  int   kc         = 0;
  int   busy_until = 0;
  bit   exp_ready  = 1'b1;
  bit   mon_en     = 1'b0;
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cke-cycle %0d)",
               nm, act, exp, kc);
    end
  endtask

  // expected events of one accepted command at cke-cycle a
  task automatic accept(input int a, input int n);
    iss_t e;
    for (int i = 0; i < n; i++) begin
      e.kc    = a + 1 + i;
      e.idx   = i;
      e.first = (i == 0);
      e.last  = (i == n - 1);
      iq.push_back(e);
    end
    busy_until = (n > 0) ? a + n + LAT + 1 : a + LAT + 2;
    dq.push_back(busy_until);
  endtask

  task automatic step(input bit rst, input bit ck,
                      input bit st, input int cnt);
    @(posedge clk);
    #1;
    reset       = rst;
    cke         = ck;
    bus.s_start = st;
    bus.s_count = CB'(cnt);
    if (rst) begin
      iq.delete();
      dq.delete();
      busy_until = 0;
    end else if (ck) begin
      kc++;
      exp_ready = (kc >= busy_until);
      if (st && exp_ready) accept(kc, cnt);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (kc < busy_until && n < 200) begin
      step(1'b0, 1'b1, 1'b0, 0);
      n++;
    end
    if (kc < busy_until) chk("wait_idle timeout", kc, busy_until);
    step(1'b0, 1'b1, 1'b0, 0);
  endtask

  always @(negedge clk) begin
    iss_t e;
    if (mon_en && cke && !reset) begin
      chk("s_ready", int'(bus.s_ready), int'(exp_ready));
      chk("busy", int'(bus.busy), int'(!exp_ready));
      if (bus.m_valid) begin
        if (iq.size() == 0) begin
          chk("unexpected m_valid", int'(bus.m_valid), 0);
        end else begin
          e = iq.pop_front();
          chk("issue slot", kc, e.kc);
          chk("m_index", int'(bus.m_index), e.idx);
          chk("m_first", int'(bus.m_first), int'(e.first));
          chk("m_last", int'(bus.m_last), int'(e.last));
        end
      end else if (iq.size() != 0 && iq[0].kc <= kc) begin
        chk("missing m_valid", int'(bus.m_valid), 1);
        void'(iq.pop_front());
      end
      if (bus.done) begin
        if (dq.size() == 0) chk("unexpected done", int'(bus.done), 0);
        else chk("done slot", kc, dq.pop_front());
      end else if (dq.size() != 0 && dq[0] <= kc) begin
        chk("missing done", int'(bus.done), 1);
        void'(dq.pop_front());
      end
    end
  end

`ifdef ELIXIRCHIP_SPU_CTL_LOOP_ABORT_EN
  initial bus.s_abort = 1'b0;
`endif

  initial begin
    bus.s_start = 1'b0;
    bus.s_count = '0;
    repeat (3) step(1'b1, 1'b1, 1'b0, 0);
    @(negedge clk);
    chk("rst s_ready", int'(bus.s_ready), 1);
    chk("rst m_valid", int'(bus.m_valid), 0);
    chk("rst m_index", int'(bus.m_index), 0);
    chk("rst m_first", int'(bus.m_first), 0);
    chk("rst m_last", int'(bus.m_last), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    mon_en = 1'b1;

    // plain loop of 4, then a single-element loop
    step(1'b0, 1'b1, 1'b1, 4);
    wait_idle();
    step(1'b0, 1'b1, 1'b1, 1);
    wait_idle();

    // stall while index 1 is presented
    step(1'b0, 1'b1, 1'b1, 5);
    step(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      chk("stall m_index", int'(bus.m_index), 1);
      chk("stall m_valid", int'(bus.m_valid), 1);
    end
    wait_idle();

    // empty loop
    step(1'b0, 1'b1, 1'b1, 0);
    wait_idle();

    // start held high: ignored while busy, taken in the done cycle
    step(1'b0, 1'b1, 1'b1, 3);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 9);
    step(1'b0, 1'b1, 1'b0, 0);
    wait_idle();

    // reset while index 2 is presented
    step(1'b0, 1'b1, 1'b1, 6);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int c;
      c = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 7));
      step($urandom_range(0, 150) == 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 2) == 0, c);
    end
    step(1'b0, 1'b1, 1'b0, 0);
    wait_idle();

    @(negedge clk);
    #1;
    chk("issue queue left", iq.size(), 0);
    chk("done queue left", dq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
